// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state type for the pipeline control unit.
// Opcodes, the M-extension funct7, the NOP encoding and FSM states.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0]  F7_M = 7'b0000001;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare between the load in execute and the decode operands.
// Purely combinational; rd x0 never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    output logic        load_use
);

    logic [6:0] fd_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_load;
    logic       use_rs1;
    logic       use_rs2;

    assign fd_op   = fd_insn[6:0];
    assign rd      = dx_insn[11:7];
    assign rs1     = fd_insn[19:15];
    assign rs2     = fd_insn[24:20];
    assign is_load = (dx_insn[6:0] == OP_LOAD);

    // U-type and JAL carry immediate bits where rs1 would sit
    assign use_rs1 = !(fd_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign use_rs2 = fd_op inside {OP_OP, OP_STORE, OP_BRANCH};

    assign load_use = is_load && (rd != 5'd0) &&
                      ((use_rs1 && rd == rs1) || (use_rs2 && rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle multiply/divide wait
// and a sticky timeout trap.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_nop,
    output logic        dx_nop,
    output logic        xm_nop,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err
);

    localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    state_t     cur;
    logic [5:0] md_cnt;
    logic [5:0] cnt_nxt;
    logic       load_use;
    logic       is_mop;

    hazard_detect u_hazard (
        .fd_insn  (fd_insn),
        .dx_insn  (dx_insn),
        .load_use (load_use)
    );

    assign is_mop = (dx_insn[6:0] == OP_OP) && (dx_insn[31:25] == F7_M);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= cnt_nxt;
        end
    end

    // Reset forces RUN decoding so the outputs are defined from time zero
    assign cur = reset ? RUN : state;

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        xm_we     = 1'b1;
        mw_we     = 1'b1;
        fd_nop    = 1'b0;
        dx_nop    = 1'b0;
        xm_nop    = 1'b0;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        md_err    = 1'b0;
        state_nxt = state;
        cnt_nxt   = '0;
        case (cur)
            RUN: begin
                if (branch_taken) begin
                    fd_nop = 1'b1;
                    dx_nop = 1'b1;
                end else if (is_mop) begin
                    md_start  = ~reset;
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_nop    = 1'b1;
                    state_nxt = MD_BUSY;
                end else if (load_use) begin
                    pc_we  = 1'b0;
                    fd_we  = 1'b0;
                    dx_nop = 1'b1;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (md_ready) begin
                    state_nxt = RUN;
                end else begin
                    pc_we  = 1'b0;
                    fd_we  = 1'b0;
                    dx_we  = 1'b0;
                    xm_nop = 1'b1;
                    if (md_cnt == CNT_LAST) begin
                        state_nxt = MD_ERR;
                    end else begin
                        cnt_nxt = md_cnt + 6'd1;
                    end
                end
            end
            MD_ERR: begin
                pc_we  = 1'b0;
                fd_we  = 1'b0;
                dx_we  = 1'b0;
                xm_we  = 1'b0;
                mw_we  = 1'b0;
                md_err = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40, giving the maximum cycles in MD_BUSY before error (legal range 2..63).
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port fd_insn, input, 32, instruction in decode.
REQ-005 SHALL have port dx_insn, input, 32, instruction in execute.
REQ-006 SHALL have port branch_taken, input, 1, execute resolved a taken branch or jump this cycle.
REQ-007 SHALL have port md_ready, input, 1, multiply/divide result valid.
REQ-008 SHALL have ports pc_we, fd_we, dx_we, xm_we, mw_we, each output, 1, write enables for the PC, FD, DX, XM and MW latches.
REQ-009 SHALL have ports fd_nop, dx_nop, xm_nop, each output, 1, replace that latch's instruction input with NOP (32'h00000013).
REQ-010 SHALL have ports md_start (1-cycle start pulse), md_busy (state is MD_BUSY) and md_err (sticky timeout flag), each output, 1.

Function
REQ-011 SHALL implement states RUN, MD_BUSY and MD_ERR; all outputs are combinational from state and inputs.
REQ-012 SHALL classify as an M-op any dx_insn with opcode 0110011 and funct7 0000001, and as a load any dx_insn with opcode 0000011.
REQ-013 SHALL flag load-use when dx is a load with rd != 0 and rd equals fd rs1 (rs1 used unless opcode is 0110111, 0010111 or 1101111) or fd rs2 (rs2 used only for 0110011, 0100011, 1100011).
REQ-014 In RUN with no hazard, SHALL assert every *_we and deassert every *_nop.
REQ-015 In RUN on load-use, SHALL drive pc_we=0, fd_we=0 and dx_nop=1; other enables stay 1; stall lasts exactly one cycle.
REQ-016 In RUN on branch_taken, SHALL drive fd_nop=1 and dx_nop=1 with all enables 1; this overrides load-use.
REQ-017 In RUN with an M-op in dx, SHALL pulse md_start=1, drive pc_we=fd_we=dx_we=0 and xm_nop=1, and transition to MD_BUSY.
REQ-018 In MD_BUSY with md_ready=0, SHALL hold pc, fd and dx, keep xm_nop=1 and md_start=0, and increment md_cnt.
REQ-019 In MD_BUSY with md_ready=1, SHALL assert all enables with xm_nop=0 so the XM latch captures the result, clear md_cnt and return to RUN.
REQ-020 SHALL leave MD_BUSY for MD_ERR when md_cnt equals MD_TIMEOUT-1 and md_ready=0; md_ready=1 on that cycle takes precedence and the unit returns to RUN.
REQ-021 In MD_ERR, SHALL drive all *_we=0 and md_err=1 and remain there until reset.
REQ-022 md_cnt SHALL be 6 bits, zero outside MD_BUSY, and never wrap.

Reset
REQ-023 On reset=1 at a rising edge, SHALL enter RUN and clear md_cnt and md_err, regardless of state, including mid MD_BUSY.
REQ-024 While reset=1, SHALL drive md_start=0; the remaining outputs follow RUN decoding.

Structure
REQ-025 SHALL place opcode constants, the funct7 M value, the NOP encoding and the state enumeration in shared package pipe_ctrl_pkg.
REQ-026 SHALL isolate the combinational load-use compare in one sub-module, hazard_detect.

Verification
REQ-027 Load-use: dx=lw x5,0(x1), fd=add x6,x5,x7 -> one cycle with pc_we=0, fd_we=0, dx_nop=1, then all enables 1.
REQ-028 No false hazard: dx=lw x0,0(x1), fd=add x6,x0,x7 -> no stall; dx=lw x5, fd=lui x5,1 -> no stall.
REQ-029 Branch beats load-use: branch_taken=1 together with load-use condition -> fd_nop=1, dx_nop=1, pc_we=1.
REQ-030 M-op: dx=mul x3,x1,x2 with md_ready rising 5 cycles after md_start -> md_start high exactly 1 cycle, md_busy for 5 cycles, xm_nop=0 and all enables 1 in the ready cycle, then RUN.
REQ-031 Timeout: MD_TIMEOUT=4, md_ready held 0 -> MD_ERR after 4 MD_BUSY cycles, md_err=1, all *_we=0 until reset.
REQ-032 Reset during MD_BUSY at cycle 2 -> next cycle state RUN, md_busy=0, md_cnt=0, md_err=0.
